// File: rtl/curl_pow_pkg.sv
// Shared definitions for the curl_pow core and its initiator-side driver.
package curl_pow_pkg;

  localparam int DATA_WIDTH     = 54;
  localparam int TRITS_IN_WORD  = 27;
  localparam int STATE_WORDS_IO = 9;
  localparam int NONCE_WORDS    = 3;
  localparam int MWM_MASK_WIDTH = 32;

  typedef logic [1:0] trit_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TF_REQ,
    TF_WAIT_HI,
    TF_WAIT_LO,
    POW_REQ,
    POW_WAIT,
    OUT
  } drv_state_e;

endpackage

// File: rtl/curl_pow_driver.sv
// Sequencer that loads a transaction into curl_pow chunk by chunk, runs the
// final PoW and streams the resulting nonce out as three beats.
module curl_pow_driver
  import curl_pow_pkg::*;
#(
  parameter int NUM_CHUNKS      = 33,
  parameter int WORDS_PER_CHUNK = STATE_WORDS_IO,
  parameter int HASH_CNT_WIDTH  = 32
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_start,
  input  logic [MWM_MASK_WIDTH-1:0]         i_mwm_mask,
  input  logic                              i_s_valid,
  output logic                              o_s_ready,
  input  logic [DATA_WIDTH-1:0]             i_s_data,
  output logic                              o_m_valid,
  input  logic                              i_m_ready,
  output logic [DATA_WIDTH-1:0]             o_m_data,
  output logic                              o_m_last,
  output logic                              o_busy,
  output logic                              o_done,
  output logic [HASH_CNT_WIDTH-1:0]         o_hash_cnt,
  output logic                              o_core_we,
  output logic [3:0]                        o_core_addr,
  output logic [DATA_WIDTH-1:0]             o_core_data,
  output logic                              o_core_transform,
  output logic                              o_core_pow,
  output logic [MWM_MASK_WIDTH-1:0]         o_core_mwm_mask,
  input  logic                              i_core_transforming,
  input  logic                              i_core_pow_hash_finish,
  input  logic                              i_core_pow_finish,
  input  logic [NONCE_WORDS*DATA_WIDTH-1:0] i_core_nonce
);

  localparam int                CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);
  localparam logic [3:0]         LAST_WORD  = 4'(WORDS_PER_CHUNK - 1);
  localparam logic [1:0]         LAST_BEAT  = 2'(NONCE_WORDS - 1);

  drv_state_e state, state_next;

  logic [CHUNK_W-1:0]                       chunk_cnt;
  logic [3:0]                               word_cnt;
  logic [1:0]                               beat_cnt;
  logic [NONCE_WORDS-1:0][DATA_WIDTH-1:0]   nonce_reg;

  logic s_fire;
  logic m_fire;
  logic last_word;
  logic last_chunk;
  logic last_beat;

  assign o_s_ready  = (state == LOAD);
  assign o_m_valid  = (state == OUT);
  assign o_busy     = (state != IDLE);
  assign o_m_last   = o_m_valid && last_beat;

  assign s_fire     = i_s_valid && o_s_ready;
  assign m_fire     = o_m_valid && i_m_ready;
  assign last_word  = (word_cnt == LAST_WORD);
  assign last_chunk = (chunk_cnt == LAST_CHUNK);
  assign last_beat  = (beat_cnt == LAST_BEAT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:       if (i_start) state_next = LOAD;
      LOAD:       if (s_fire && last_word) state_next = last_chunk ? POW_REQ : TF_REQ;
      TF_REQ:     state_next = TF_WAIT_HI;
      TF_WAIT_HI: if (i_core_transforming) state_next = TF_WAIT_LO;
      TF_WAIT_LO: if (!i_core_transforming) state_next = LOAD;
      POW_REQ:    state_next = POW_WAIT;
      POW_WAIT:   if (i_core_pow_finish) state_next = OUT;
      OUT:        if (m_fire && last_beat) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Core strobes are registered, so each request lands one cycle after the
  // state that raises it; this also lets the last chunk write settle first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_core_we        <= 1'b0;
      o_core_addr      <= '0;
      o_core_data      <= '0;
      o_core_transform <= 1'b0;
      o_core_pow       <= 1'b0;
      o_core_mwm_mask  <= '0;
      o_hash_cnt       <= '0;
      o_done           <= 1'b0;
      chunk_cnt        <= '0;
      word_cnt         <= '0;
      beat_cnt         <= '0;
      nonce_reg        <= '0;
    end else begin
      o_core_we        <= 1'b0;
      o_core_transform <= 1'b0;
      o_core_pow       <= 1'b0;
      o_done           <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            o_core_mwm_mask <= i_mwm_mask;
            chunk_cnt       <= '0;
            word_cnt        <= '0;
            o_hash_cnt      <= '0;
          end
        end
        LOAD: begin
          if (s_fire) begin
            o_core_we   <= 1'b1;
            o_core_addr <= word_cnt;
            o_core_data <= i_s_data;
            word_cnt    <= last_word ? 4'd0 : word_cnt + 4'd1;
          end
        end
        TF_REQ: o_core_transform <= 1'b1;
        TF_WAIT_LO: begin
          if (!i_core_transforming) chunk_cnt <= chunk_cnt + 1'b1;
        end
        POW_REQ: o_core_pow <= 1'b1;
        POW_WAIT: begin
          if (i_core_pow_hash_finish && (o_hash_cnt != '1)) begin
            o_hash_cnt <= o_hash_cnt + 1'b1;
          end
          if (i_core_pow_finish) begin
            nonce_reg <= i_core_nonce;
            beat_cnt  <= '0;
          end
        end
        OUT: begin
          if (m_fire) begin
            if (last_beat) begin
              beat_cnt <= '0;
              o_done   <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_m_data = nonce_reg[0];
    case (beat_cnt)
      2'd1:    o_m_data = nonce_reg[1];
      2'd2:    o_m_data = nonce_reg[2];
      default: o_m_data = nonce_reg[0];
    endcase
  end

endmodule

// File: tb/tb_curl_pow_driver.sv
// Scoreboard bench for curl_pow_driver with a small behavioural curl_pow core.
module tb_curl_pow_driver;
  import curl_pow_pkg::*;

  localparam int TIMEOUT = 3000;
  localparam int WPC     = 9;

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_start = 1'b0;
  logic [31:0]  i_mwm_mask = '0;
  logic         i_s_valid = 1'b0;
  logic         o_s_ready;
  logic [53:0]  i_s_data = '0;
  logic         o_m_valid;
  logic         i_m_ready = 1'b0;
  logic [53:0]  o_m_data;
  logic         o_m_last;
  logic         o_busy;
  logic         o_done;
  logic [31:0]  o_hash_cnt;
  logic         o_core_we;
  logic [3:0]   o_core_addr;
  logic [53:0]  o_core_data;
  logic         o_core_transform;
  logic         o_core_pow;
  logic [31:0]  o_core_mwm_mask;
  logic         i_core_transforming = 1'b0;
  logic         i_core_pow_hash_finish = 1'b0;
  logic         i_core_pow_finish = 1'b0;
  logic [161:0] i_core_nonce = '0;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  int tf_pulses = 0;
  int pow_pulses = 0;
  int tf_base, pow_base;
  bit coincide = 1'b0;

  logic [3:0]  exp_addr[$];
  logic [53:0] exp_data[$];
  logic [54:0] exp_beat[$];

  curl_pow_driver #(.NUM_CHUNKS(2)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_mwm_mask(i_mwm_mask),
    .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .i_s_data(i_s_data),
    .o_m_valid(o_m_valid), .i_m_ready(i_m_ready), .o_m_data(o_m_data), .o_m_last(o_m_last),
    .o_busy(o_busy), .o_done(o_done), .o_hash_cnt(o_hash_cnt),
    .o_core_we(o_core_we), .o_core_addr(o_core_addr), .o_core_data(o_core_data),
    .o_core_transform(o_core_transform), .o_core_pow(o_core_pow),
    .o_core_mwm_mask(o_core_mwm_mask),
    .i_core_transforming(i_core_transforming),
    .i_core_pow_hash_finish(i_core_pow_hash_finish),
    .i_core_pow_finish(i_core_pow_finish), .i_core_nonce(i_core_nonce)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Behavioural core: 12-cycle transform, 5 hash pulses per PoW, and a stray
  // hash pulse on every transform request that the driver must not count.
  int tf_left = 0;
  int hash_left = 0;
  bit fin_pending = 1'b0;
  always begin
    @(posedge clk); #1;
    i_core_pow_hash_finish = 1'b0;
    i_core_pow_finish = 1'b0;
    if (i_rst) begin
      i_core_transforming = 1'b0;
      tf_left = 0;
      hash_left = 0;
      fin_pending = 1'b0;
    end else begin
      if (tf_left > 0) begin
        tf_left--;
        if (tf_left == 0) i_core_transforming = 1'b0;
      end
      if (hash_left > 0) begin
        i_core_pow_hash_finish = 1'b1;
        hash_left--;
        if (hash_left == 0) begin
          if (coincide) i_core_pow_finish = 1'b1;
          else fin_pending = 1'b1;
        end
      end else if (fin_pending) begin
        i_core_pow_finish = 1'b1;
        fin_pending = 1'b0;
      end
      if (o_core_transform) begin
        tf_pulses++;
        i_core_transforming = 1'b1;
        tf_left = 12;
        i_core_pow_hash_finish = 1'b1;
      end
      if (o_core_pow) begin
        pow_pulses++;
        hash_left = 5;
      end
    end
  end

  always @(negedge clk) begin
    if (o_done) done_cnt++;
    if (o_core_transform && o_core_pow) overlap_cnt++;
    if (o_core_we) begin
      check_output("we_pending", 64'(exp_addr.size() > 0), 64'd1);
      if (exp_addr.size() > 0) begin
        check_output("core_addr", 64'(o_core_addr), 64'(exp_addr.pop_front()));
        check_output("core_data", 64'(o_core_data), 64'(exp_data.pop_front()));
      end
    end
    if (o_m_valid && i_m_ready) begin
      check_output("beat_pending", 64'(exp_beat.size() > 0), 64'd1);
      if (exp_beat.size() > 0) begin
        logic [54:0] b;
        b = exp_beat.pop_front();
        check_output("m_data", 64'(o_m_data), 64'(b[53:0]));
        check_output("m_last", 64'(o_m_last), 64'(b[54]));
      end
    end
  end

  task automatic start_job(input logic [31:0] mask);
    @(posedge clk); #1;
    i_start = 1'b1;
    i_mwm_mask = mask;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    check_output("start_busy", 64'(o_busy), 64'd1);
    check_output("start_ready", 64'(o_s_ready), 64'd1);
    check_output("start_mask", 64'(o_core_mwm_mask), 64'(mask));
    check_output("start_hash_clr", 64'(o_hash_cnt), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic apply_stimulus(input int n, input logic [53:0] dbase, input logic [53:0] dstep,
                                input int bubble_from, input int start_at);
    for (int i = 0; i < n; i++) begin
      int waited;
      bit fired;
      waited = 0;
      fired = 1'b0;
      i_s_valid = 1'b1;
      i_s_data = dbase + dstep * 54'(i);
      if (i == start_at) begin
        i_start = 1'b1;
        i_mwm_mask = 32'hFFFF_FFFF;
      end
      while (!fired && waited < TIMEOUT) begin
        @(negedge clk);
        fired = o_s_ready;
        if (fired) begin
          exp_addr.push_back(4'(i % WPC));
          exp_data.push_back(i_s_data);
        end
        @(posedge clk); #1;
        i_start = 1'b0;
        waited++;
      end
      check_output("s_handshake", 64'(fired), 64'd1);
      if (i >= bubble_from) begin
        i_s_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    i_s_valid = 1'b0;
  endtask

  task automatic wait_done(input logic [31:0] mask);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < TIMEOUT && !seen; c++) begin
      @(negedge clk);
      if (o_done) begin
        seen = 1'b1;
        check_output("done_hash_cnt", 64'(o_hash_cnt), 64'd5);
        check_output("done_busy", 64'(o_busy), 64'd0);
        check_output("done_mask", 64'(o_core_mwm_mask), 64'(mask));
      end
    end
    check_output("done_seen", 64'(seen), 64'd1);
    @(negedge clk);
    check_output("done_one_cycle", 64'(o_done), 64'd0);
  endtask

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_busy", 64'(o_busy), 64'd0);
    check_output("rst_s_ready", 64'(o_s_ready), 64'd0);
    check_output("rst_m_valid", 64'(o_m_valid), 64'd0);
    check_output("rst_strobes", 64'({o_done, o_core_we, o_core_transform, o_core_pow, o_m_last}), 64'd0);
    check_output("rst_core_bus", 64'({o_core_addr, o_core_data}), 64'd0);
    check_output("rst_hash_mask", 64'({o_hash_cnt, o_core_mwm_mask}), 64'd0);
    @(posedge clk); #1;
    i_rst = 1'b0;

    // Job 1: constant data, bubbles in the second chunk, ignored mid-LOAD start
    i_core_nonce = {54'hC, 54'hB, 54'hA};
    coincide = 1'b0;
    exp_beat.push_back({1'b0, 54'hA});
    exp_beat.push_back({1'b0, 54'hB});
    exp_beat.push_back({1'b1, 54'hC});
    tf_base = tf_pulses;
    pow_base = pow_pulses;
    start_job(32'h0000_3FFF);
    apply_stimulus(18, 54'h15, 54'h0, 9, 4);
    i_m_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < TIMEOUT && !seen; c++) begin
      @(negedge clk);
      seen = o_m_valid;
    end
    check_output("m_valid_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
    i_m_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_output("stall_valid", 64'(o_m_valid), 64'd1);
      check_output("stall_data", 64'(o_m_data), 64'hB);
      check_output("stall_no_done", 64'(o_done), 64'd0);
    end
    @(posedge clk); #1;
    i_m_ready = 1'b1;
    wait_done(32'h0000_3FFF);
    check_output("job1_tf_pulses", 64'(tf_pulses - tf_base), 64'd1);
    check_output("job1_pow_pulses", 64'(pow_pulses - pow_base), 64'd1);

    // Job 2: abandoned by reset while the core is mid-transform
    start_job(32'h1234_5678);
    apply_stimulus(9, 54'h100, 54'h1, 99, -1);
    seen = 1'b0;
    for (int c = 0; c < TIMEOUT && !seen; c++) begin
      @(negedge clk);
      seen = i_core_transforming;
    end
    check_output("tf_started", 64'(seen), 64'd1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    i_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("midrst_busy", 64'(o_busy), 64'd0);
    check_output("midrst_s_ready", 64'(o_s_ready), 64'd0);
    check_output("midrst_state", 64'(dut.state), 64'(IDLE));
    check_output("midrst_mask", 64'(o_core_mwm_mask), 64'd0);
    @(posedge clk); #1;
    i_rst = 1'b0;

    // Job 3: final hash pulse coincides with PoW finish; edge-valued nonce
    i_core_nonce = {54'h3F_FFFF_FFFF_FFFF, 54'h1, 54'h20_0000_0000_0000};
    coincide = 1'b1;
    exp_beat.push_back({1'b0, 54'h20_0000_0000_0000});
    exp_beat.push_back({1'b0, 54'h1});
    exp_beat.push_back({1'b1, 54'h3F_FFFF_FFFF_FFFF});
    tf_base = tf_pulses;
    pow_base = pow_pulses;
    start_job(32'h0000_00FF);
    apply_stimulus(18, 54'h200, 54'h3, 99, -1);
    i_m_ready = 1'b1;
    wait_done(32'h0000_00FF);
    check_output("job3_tf_pulses", 64'(tf_pulses - tf_base), 64'd1);
    check_output("job3_pow_pulses", 64'(pow_pulses - pow_base), 64'd1);

    repeat (3) @(negedge clk);
    check_output("done_total", 64'(done_cnt), 64'd2);
    check_output("tf_pow_overlap", 64'(overlap_cnt), 64'd0);
    check_output("writes_left", 64'(exp_addr.size()), 64'd0);
    check_output("beats_left", 64'(exp_beat.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
